// File: rtl/mem_chk_pkg.sv
// Shared types and default parameters for the store-sequence checker.
// The state enum is also what the checker's FSM register uses.
package mem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_N_EXP   = 4;
    localparam int DEF_TIMEOUT = 500;
    localparam int DEF_STRICT  = 0;

    // A single-entry table still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_chk_table.sv
// Expected-store table: one synchronous write port, one combinational read port.
// Contents have no reset so that a loaded table survives a checker reset.
module mem_chk_table
    import mem_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_EXP  = DEF_N_EXP,
    parameter int IDX_W  = idx_width(DEF_N_EXP)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_byte_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_byte_o
);

    logic [ADDR_W-1:0] addr_q [N_EXP];
    logic [DATA_W-1:0] data_q [N_EXP];
    logic              byte_q [N_EXP];

    // Indices at or beyond N_EXP are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (we_i && (32'(wr_idx_i) < N_EXP)) begin
            addr_q[wr_idx_i] <= wr_addr_i;
            data_q[wr_idx_i] <= wr_data_i;
            byte_q[wr_idx_i] <= wr_byte_i;
        end
    end

    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        rd_byte_o = 1'b0;
        if (32'(rd_idx_i) < N_EXP) begin
            rd_addr_o = addr_q[rd_idx_i];
            rd_data_o = data_q[rd_idx_i];
            rd_byte_o = byte_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Watches processor stores during a run and checks them, in order, against a
// table of expected stores; reports pass, mismatch failure or timeout.
module mem_write_checker
    import mem_chk_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_EXP   = DEF_N_EXP,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int STRICT  = DEF_STRICT,
    localparam int IDX_W  = idx_width(N_EXP),
    localparam int CNT_W  = $clog2(N_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              MemWrite,
    input  logic              ByteMem,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_byte,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [15:0]       write_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (N_EXP < 1) begin : g_bad_n_exp
        $error("mem_write_checker: N_EXP must be at least 1");
    end

    chk_state_e        state_q;
    logic              busy_q, done_q, pass_q, fail_q, timed_out_q;
    logic [CNT_W-1:0]  match_cnt_q;
    logic [15:0]       write_cnt_q;
    logic [15:0]       write_cnt_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              exp_byte;
    logic              data_eq;
    logic              store_hit;
    logic              store_miss;
    logic              last_match;
    logic              to_expired;

    mem_chk_table #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_EXP  (N_EXP),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk       (clk),
        .we_i      (cfg_we && (state_q == ST_IDLE)),
        .wr_idx_i  (cfg_idx),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .wr_byte_i (cfg_byte),
        .rd_idx_i  (match_cnt_q[IDX_W-1:0]),
        .rd_addr_o (exp_addr),
        .rd_data_o (exp_data),
        .rd_byte_o (exp_byte)
    );

    // Byte entries compare only the low data byte; ByteMem itself must still agree.
    assign data_eq    = exp_byte ? (WriteData[7:0] == exp_data[7:0]) : (WriteData == exp_data);
    assign store_hit  = MemWrite && (DataAdr == exp_addr) && (ByteMem == exp_byte) && data_eq;
    assign store_miss = MemWrite && !store_hit;
    assign last_match = (match_cnt_q == CNT_W'(N_EXP - 1));
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign write_cnt_d = (write_cnt_q == 16'hFFFF) ? write_cnt_q : write_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timed_out_q <= 1'b0;
            match_cnt_q <= '0;
            write_cnt_q <= '0;
            to_cnt_q    <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                        match_cnt_q <= '0;
                        write_cnt_q <= '0;
                        to_cnt_q    <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                    end
                end
                ST_RUN: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (MemWrite) begin
                        write_cnt_q <= write_cnt_d;
                    end
                    // Final match is checked first so it wins over a same-cycle timeout.
                    if (store_hit && last_match) begin
                        state_q     <= ST_PASS;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b1;
                        match_cnt_q <= match_cnt_q + CNT_W'(1);
                    end else begin
                        if (store_hit) begin
                            match_cnt_q <= match_cnt_q + CNT_W'(1);
                        end
                        if (store_miss && (STRICT != 0)) begin
                            state_q     <= ST_FAIL;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                            fail_addr_q <= DataAdr;
                            fail_data_q <= WriteData;
                        end else if (to_expired) begin
                            state_q     <= ST_FAIL;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            fail_q      <= 1'b1;
                            timed_out_q <= 1'b1;
                        end
                    end
                end
                ST_PASS, ST_FAIL: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timed_out = timed_out_q;
    assign match_cnt = match_cnt_q;
    assign write_cnt = write_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three instances (lenient, strict, single-entry strict)
// share one stimulus stream; a store-list model predicts each run's outcome.
module tb_mem_write_checker;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic        ByteMem = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_byte = 1'b0;

    logic        busy_w [3];
    logic        done_w [3];
    logic        pass_w [3];
    logic        fail_w [3];
    logic        to_w   [3];
    logic [15:0] wc_w   [3];
    logic [31:0] fa_w   [3];
    logic [31:0] fd_w   [3];
    logic [31:0] mc_w   [3];
    logic [1:0]  mc0, mc1;
    logic [0:0]  mc2;

    assign mc_w[0] = 32'(mc0);
    assign mc_w[1] = 32'(mc1);
    assign mc_w[2] = 32'(mc2);

    always #5 clk = ~clk;

    mem_write_checker #(.DATA_W(32), .ADDR_W(32), .N_EXP(2), .TIMEOUT(T), .STRICT(0)) u_lax (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .ByteMem(ByteMem),
        .DataAdr(DataAdr), .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_byte(cfg_byte),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
        .timed_out(to_w[0]), .match_cnt(mc0), .write_cnt(wc_w[0]),
        .fail_addr(fa_w[0]), .fail_data(fd_w[0]));

    mem_write_checker #(.DATA_W(32), .ADDR_W(32), .N_EXP(2), .TIMEOUT(T), .STRICT(1)) u_strict (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .ByteMem(ByteMem),
        .DataAdr(DataAdr), .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_byte(cfg_byte),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
        .timed_out(to_w[1]), .match_cnt(mc1), .write_cnt(wc_w[1]),
        .fail_addr(fa_w[1]), .fail_data(fd_w[1]));

    mem_write_checker #(.DATA_W(32), .ADDR_W(32), .N_EXP(1), .TIMEOUT(T), .STRICT(1)) u_one (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .ByteMem(ByteMem),
        .DataAdr(DataAdr), .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_byte(cfg_byte),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]),
        .timed_out(to_w[2]), .match_cnt(mc2), .write_cnt(wc_w[2]),
        .fail_addr(fa_w[2]), .fail_data(fd_w[2]));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          byt;
    } ent_t;

    typedef struct {
        int          edge_no;
        bit          ps;
        bit          fl;
        bit          to;
        int          mc;
        int          wc;
        logic [31:0] fa;
        logic [31:0] fd;
    } exp_t;

    ent_t        tbl_m [3][2];
    bit          slot_v [T];
    logic [31:0] slot_a [T];
    logic [31:0] slot_d [T];
    bit          slot_b [T];
    exp_t        exp_q [3][$];
    exp_t        last_exp [3];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic int n_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic bit strict_of(input int k);
        return k != 0;
    endfunction

    // Walk the run's store list in order: each store either advances the
    // expected-entry pointer, ends a strict run, or is ignored.
    function automatic exp_t model(input int k, input int run_edge);
        exp_t r;
        int   matched;
        int   end_c;
        bit   hit;
        ent_t e;
        matched = 0;
        end_c = T - 1;
        r.ps = 0; r.fl = 1; r.to = 1; r.wc = 0; r.fa = '0; r.fd = '0;
        for (int c = 0; c < T; c++) begin
            if (slot_v[c]) begin
                r.wc++;
                e = tbl_m[k][matched];
                hit = (slot_a[c] == e.addr) && (slot_b[c] == e.byt) &&
                      (e.byt ? (slot_d[c][7:0] == e.data[7:0]) : (slot_d[c] == e.data));
                if (hit) begin
                    matched++;
                    if (matched == n_of(k)) begin
                        r.ps = 1; r.fl = 0; r.to = 0;
                        end_c = c;
                        break;
                    end
                end else if (strict_of(k)) begin
                    r.to = 0;
                    r.fa = slot_a[c];
                    r.fd = slot_d[c];
                    end_c = c;
                    break;
                end
            end
        end
        r.mc = matched;
        r.edge_no = run_edge + end_c + 1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Monitor: whenever an instance raises done, pop its prediction and compare.
    initial begin
        bit   prev_done [3];
        exp_t me;
        for (int k = 0; k < 3; k++) prev_done[k] = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done_w[k] && !prev_done[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("u%0d.unexpected_done", k), 1, 0);
                    end else begin
                        me = exp_q[k].pop_front();
                        $display("u%0d run done at edge %0d: pass=%0d fail=%0d to=%0d mc=%0d wc=%0d",
                                 k, cyc, pass_w[k], fail_w[k], to_w[k], mc_w[k], wc_w[k]);
                        chk($sformatf("u%0d.done_edge", k), cyc, me.edge_no);
                        chk($sformatf("u%0d.pass", k), pass_w[k], me.ps);
                        chk($sformatf("u%0d.fail", k), fail_w[k], me.fl);
                        chk($sformatf("u%0d.timed_out", k), to_w[k], me.to);
                        chk($sformatf("u%0d.match_cnt", k), mc_w[k], me.mc);
                        chk($sformatf("u%0d.write_cnt", k), wc_w[k], me.wc);
                        chk($sformatf("u%0d.fail_addr", k), fa_w[k], me.fa);
                        chk($sformatf("u%0d.fail_data", k), fd_w[k], me.fd);
                    end
                end
                prev_done[k] = done_w[k];
            end
        end
    end

    task automatic quiet_inputs();
        start = 1'b0; MemWrite = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d, input bit b);
        @(negedge clk);
        quiet_inputs();
        cfg_we = 1'b1; cfg_idx = idx[0]; cfg_addr = a; cfg_data = d; cfg_byte = b;
        for (int k = 0; k < 3; k++) begin
            if (idx < n_of(k)) tbl_m[k][idx] = '{addr: a, data: d, byt: b};
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic clear_slots();
        for (int c = 0; c < T; c++) begin
            slot_v[c] = 0; slot_a[c] = '0; slot_d[c] = '0; slot_b[c] = 0;
        end
    endtask

    task automatic set_slot(input int c, input logic [31:0] a, input logic [31:0] d, input bit b);
        slot_v[c] = 1; slot_a[c] = a; slot_d[c] = d; slot_b[c] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        quiet_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.rst_flags", k),
                {busy_w[k], done_w[k], pass_w[k], fail_w[k], to_w[k]}, 5'b0);
            chk($sformatf("u%0d.rst_counts", k), {mc_w[k], wc_w[k]}, '0);
            chk($sformatf("u%0d.rst_capture", k), {fa_w[k], fd_w[k]}, '0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One run: start pulse (with an ignored store alongside), T RUN cycles of slots,
    // then a check that results hold both in PASS/FAIL and after returning to IDLE.
    task automatic do_run(input bit hold);
        int run_edge;
        @(negedge clk);
        start = 1'b1; cfg_we = 1'b0;
        MemWrite = 1'b1; DataAdr = tbl_m[0][0].addr;
        WriteData = tbl_m[0][0].data; ByteMem = tbl_m[0][0].byt;
        run_edge = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            last_exp[k] = model(k, run_edge);
            exp_q[k].push_back(last_exp[k]);
        end
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int k = 0; k < 3; k++) chk($sformatf("u%0d.busy_run", k), busy_w[k], 1);
            end
            start = hold;
            MemWrite = slot_v[c]; DataAdr = slot_a[c]; WriteData = slot_d[c]; ByteMem = slot_b[c];
            if (hold) begin
                cfg_we = 1'b1; cfg_idx = 1'($urandom); cfg_addr = $urandom;
                cfg_data = $urandom; cfg_byte = 1'($urandom);
            end
        end
        @(negedge clk);
        MemWrite = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.done_hold", k), done_w[k], 1);
            chk($sformatf("u%0d.pass_hold", k), pass_w[k], last_exp[k].ps);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.idle_result", k),
                {busy_w[k], pass_w[k], fail_w[k]}, {1'b0, last_exp[k].ps, last_exp[k].fl});
        end
    endtask

    function automatic logic [31:0] pool_addr();
        return 32'd100 + 32'(4 * $urandom_range(3, 0));
    endfunction

    initial begin
        ent_t e;
        int   pick;
        repeat (3) @(negedge clk);
        do_reset();

        // Single-entry pass on u_one; two-entry instances time out after one match.
        cfg_write(0, 32'd200, 32'd5, 0);
        cfg_write(1, 32'd204, 32'd6, 0);
        clear_slots(); set_slot(2, 32'd200, 32'd5, 0);
        do_run(1);

        // Strict mismatch capture, then lenient skip of a stray store.
        cfg_write(0, 32'd100, 32'd7, 0);
        cfg_write(1, 32'd104, 32'd9, 0);
        clear_slots(); set_slot(1, 32'd100, 32'd7, 0); set_slot(3, 32'd108, 32'd3, 0);
        do_run(1);
        clear_slots(); set_slot(0, 32'd60, 32'd1, 0); set_slot(4, 32'd100, 32'd7, 0);
        set_slot(8, 32'd104, 32'd9, 0);
        do_run(0);

        // Pure timeout, and final match landing in the last RUN cycle.
        clear_slots();
        do_run(1);
        clear_slots(); set_slot(5, 32'd100, 32'd7, 0); set_slot(T - 1, 32'd104, 32'd9, 0);
        do_run(1);

        // Byte entry: upper data bits ignored, ByteMem must agree.
        cfg_write(0, 32'd50, 32'h0000_00AB, 1);
        cfg_write(1, 32'd54, 32'h1234_5678, 0);
        clear_slots(); set_slot(1, 32'd50, 32'hFFFF_FFAB, 1); set_slot(2, 32'd54, 32'h1234_5678, 0);
        do_run(1);
        clear_slots(); set_slot(1, 32'd50, 32'hFFFF_FFAB, 0);
        do_run(1);

        // Reset in the middle of a run, then rerun with the retained table.
        clear_slots();
        @(negedge clk);
        start = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("u%0d.busy_pre_rst", k), busy_w[k], 1);
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("u%0d.busy_post_rst", k), busy_w[k], 0);
        clear_slots(); set_slot(3, 32'd50, 32'h5555_55AB, 1); set_slot(7, 32'd54, 32'h1234_5678, 0);
        do_run(1);

        // Randomized runs over a small address/data pool so matches are frequent.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 2; i++) begin
                    cfg_write(i, pool_addr(), {24'($urandom), 8'($urandom_range(3, 0))},
                              $urandom_range(1, 0) == 1);
                end
            end
            clear_slots();
            for (int c = 0; c < T; c++) begin
                if ($urandom_range(2, 0) == 0) begin
                    pick = $urandom_range(3, 0);
                    if (pick < 2) begin
                        e = tbl_m[0][pick];
                        set_slot(c, e.addr, e.byt ? {24'($urandom), e.data[7:0]} : e.data,
                                 ($urandom_range(7, 0) == 0) ? !e.byt : e.byt);
                    end else begin
                        set_slot(c, pool_addr(), 32'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
                    end
                end
            end
            do_run($urandom_range(1, 0) == 1);
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.pending_results", k), exp_q[k].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DATA_W, default 32, width of the observed store data and the expected data.
REQ-002 Parameter ADDR_W, default 32, width of the observed store address and the expected address.
REQ-003 Parameter N_EXP, default 4, number of expected stores; values below 1 SHALL be illegal.
REQ-004 Parameter TIMEOUT, default 500, number of RUN cycles allowed before the run fails.
REQ-005 Parameter STRICT, default 0; 1 = any non-matching store fails the run, 0 = non-matching stores are ignored.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  level; arms a check run.
REQ-009 MemWrite  input  1  store strobe from the processor.
REQ-010 ByteMem  input  1  store is byte-wide.
REQ-011 DataAdr  input  ADDR_W  store address.
REQ-012 WriteData  input  DATA_W  store data.
REQ-013 cfg_we  input  1  expectation-table write strobe.
REQ-014 cfg_idx  input  $clog2(N_EXP) or 1  expectation-table entry index.
REQ-015 cfg_addr, cfg_data, cfg_byte  input  ADDR_W, DATA_W, 1  expected address, data and ByteMem for the entry.
REQ-016 busy, done, pass, fail, timed_out  output  1 each  run status.
REQ-017 match_cnt  output  $clog2(N_EXP+1)  matched entries so far.
REQ-018 write_cnt  output  16  stores seen in RUN; saturates at 0xFFFF.
REQ-019 fail_addr, fail_data  output  ADDR_W, DATA_W  store captured at the failure.

Function
REQ-020 States SHALL be IDLE, RUN, PASS and FAIL.
REQ-021 In IDLE, cfg_we=1 SHALL write entry cfg_idx in one cycle; cfg_we outside IDLE, or with cfg_idx>=N_EXP, SHALL be ignored.
REQ-022 IDLE with start=1 SHALL go to RUN on the next edge, clearing match_cnt, write_cnt, the timeout counter, fail_addr and fail_data; a store in that same cycle SHALL NOT be checked.
REQ-023 In RUN, a cycle with MemWrite=1 SHALL increment write_cnt and compare the store against entry[match_cnt].
REQ-024 A store SHALL match when DataAdr, ByteMem and the data are all equal to the entry; when the entry's byte flag is 1, only WriteData[7:0] SHALL be compared.
REQ-025 A match SHALL increment match_cnt; when it is the match that brings match_cnt to N_EXP, the next state SHALL be PASS.
REQ-026 A mismatch with STRICT=1 SHALL go to FAIL and capture DataAdr into fail_addr and WriteData into fail_data; with STRICT=0 a mismatch SHALL have no effect beyond the write_cnt increment.
REQ-027 The timeout counter SHALL increment every RUN cycle; at TIMEOUT-1 with no pass, the next state SHALL be FAIL, timed_out SHALL be set and fail_addr and fail_data SHALL be left at 0.
REQ-028 If the final match and the timeout occur in the same cycle, PASS SHALL take priority.
REQ-029 PASS and FAIL SHALL hold while start=1 and SHALL return to IDLE on the first cycle with start=0; status flags, counters and captures SHALL hold until the next run starts.
REQ-030 Outputs SHALL be registered: busy=RUN, done=PASS|FAIL, pass=PASS, fail=FAIL, each valid one cycle after the state change.
REQ-031 Dropping start during RUN SHALL NOT abort the run.

Reset
REQ-032 reset=1 SHALL force IDLE and zero every output (busy, done, pass, fail, timed_out, match_cnt, write_cnt, fail_addr, fail_data) on the next edge, including mid-run.
REQ-033 Expectation-table contents SHALL NOT be reset; they are retained across reset.

Structure
REQ-034 Package mem_chk_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 The expectation storage SHALL be sub-module mem_chk_table: N_EXP entries, one synchronous write port and one combinational read port.

Verification
REQ-036 N_EXP=1, entry {200,5,byte 0}; start, then a store to 200 with data 5 -> pass=1, match_cnt=1.
REQ-037 STRICT=1, entries {100,7},{104,9}; stores (100,7) then (108,3) -> fail=1, fail_addr=108, fail_data=3, match_cnt=1.
REQ-038 STRICT=0, same entries; stores (60,1),(100,7),(104,9) -> pass=1, write_cnt=3.
REQ-039 TIMEOUT=20 and no stores -> fail=1 and timed_out=1 exactly 20 cycles after RUN entry; TIMEOUT=20 with the final match in cycle 19 -> pass=1.
REQ-040 Byte entry {50,0x000000AB,byte 1}; store (50,0xFFFFFFAB,ByteMem=1) -> pass; the same store with ByteMem=0 -> no match.
REQ-041 reset asserted mid-RUN -> all outputs 0, state IDLE; a restart with no reload passes using the retained table.
